// File: rtl/fadd_pkg.sv
// Shared types and widths for the single-precision FP add path.
// Contents: field widths, biased-exponent ceiling, the post-adder
// normalizer state encoding and the packed IEEE-754 word layout.
package fadd_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    // Adder-stage magnitude: carry + hidden + FRAC_W fraction bits
    localparam int unsigned MAG_W  = FRAC_W + 2;
    // Working fraction after the carry has been folded in: hidden + fraction
    localparam int unsigned F_W    = FRAC_W + 1;
    // One guard bit so exponent arithmetic can never wrap
    localparam int unsigned EXPI_W = EXP_W + 1;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } norm_state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

endpackage

// File: rtl/fadd_lzc_step.sv
// Leading-zero count over the top SHIFT_PER_CYCLE bits of the working
// fraction; the count saturates at SHIFT_PER_CYCLE when all of them are 0.
// Ports:
//   top_bits  in   SHIFT_PER_CYCLE MSBs of the fraction (MSB = hidden bit)
//   lz_c      out  combinational leading-zero count, 0..SHIFT_PER_CYCLE
module fadd_lzc_step
    import fadd_pkg::*;
#(
    parameter int unsigned SHIFT_PER_CYCLE = 1,
    localparam int unsigned LZ_W = $clog2(SHIFT_PER_CYCLE + 1)
) (
    input  logic [SHIFT_PER_CYCLE-1:0] top_bits,
    output logic [LZ_W-1:0]            lz_c
);

    localparam int SPC = int'(SHIFT_PER_CYCLE);

    // Scan from the least significant position upward so the highest set
    // bit is the last one to overwrite the count.
    always_comb begin
        lz_c = LZ_W'(SHIFT_PER_CYCLE);
        for (int i = SPC - 1; i >= 0; i--) begin
            if (top_bits[SPC-1-i]) begin
                lz_c = LZ_W'(i);
            end
        end
    end

endmodule

// File: rtl/fadd_norm_seq.sv
// Sequential post-adder normalizer: folds the adder carry, left-normalizes
// cancellation SHIFT_PER_CYCLE bits per cycle and packs an IEEE-754 word.
// Rounding is truncation.
// Optional macro FADD_NORM_FLAGS_EN adds flags[2:0] = {ovf_inf, subnormal, zero}.
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   in_valid/in_ready   upstream handshake; in_ready only in IDLE
//   in_sign/in_exp      sign and larger operand's biased exponent
//   in_frac             25-bit magnitude: bit24 carry, bit23 hidden
//   out_valid/out_ready downstream handshake; out_valid only in DONE
//   out                 packed {sign, exp, frac}, held until next result
//   busy                high whenever not IDLE
//   flags               (FADD_NORM_FLAGS_EN) registered with out
module fadd_norm_seq
    import fadd_pkg::*;
#(
    parameter int unsigned SHIFT_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MAG_W-1:0]  in_frac,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out,
    output logic              busy
`ifdef FADD_NORM_FLAGS_EN
    ,
    output logic [2:0]        flags
`endif
);

    localparam int unsigned LZ_W = $clog2(SHIFT_PER_CYCLE + 1);

    norm_state_t          state_q, state_d;
    logic                 sign_q, sign_d;
    logic [EXPI_W-1:0]    e_q, e_d;
    logic [F_W-1:0]       f_q, f_d;
    fp32_t                out_q, out_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;
`ifdef FADD_NORM_FLAGS_EN
    logic [2:0]           flags_q, flags_d;
`endif

    logic                 in_zero, in_carry, in_done;
    logic [EXPI_W-1:0]    in_e_inc;
    logic [LZ_W-1:0]      lz_step;
    logic [EXPI_W-1:0]    e_m1, lz_eff, step_e;
    logic [F_W-1:0]       step_f;
    logic                 step_exit;
    logic                 load_out;
    logic [EXP_W-1:0]     out_exp;

    // Per-cycle leading-zero count of the window at the top of the fraction
    fadd_lzc_step #(
        .SHIFT_PER_CYCLE (SHIFT_PER_CYCLE)
    ) u_lzc (
        .top_bits (f_q[F_W-1 -: SHIFT_PER_CYCLE]),
        .lz_c     (lz_step)
    );

    // Input classification for the accept cycle
    always_comb begin
        in_zero  = (in_frac == '0);
        in_carry = in_frac[MAG_W-1];
        in_e_inc = {1'b0, in_exp} + EXPI_W'(1);
        in_done  = in_zero || in_carry || in_frac[F_W-1] || (in_exp == '0);
    end

    // One shift step; the cap at e-1 stops normalization at the subnormal floor
    always_comb begin
        e_m1      = e_q - EXPI_W'(1);
        lz_eff    = (EXPI_W'(lz_step) > e_m1) ? e_m1 : EXPI_W'(lz_step);
        step_f    = f_q << lz_eff;
        step_e    = e_q - lz_eff;
        step_exit = step_f[F_W-1] || (step_e == EXPI_W'(1));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = in_done ? DONE : SHIFT;
            SHIFT:   if (step_exit) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        sign_d = sign_q;
        e_d    = e_q;
        f_d    = f_q;
        out_d  = out_q;
`ifdef FADD_NORM_FLAGS_EN
        flags_d = flags_q;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = in_sign;
                    e_d    = {1'b0, in_exp};
                    f_d    = in_frac[F_W-1:0];
                    if (in_zero) begin
                        sign_d = 1'b0;
                        e_d    = '0;
                        f_d    = '0;
                    end else if (in_carry) begin
                        f_d = in_frac[MAG_W-1:1];
                        e_d = in_e_inc;
                        // Carry pushed the exponent to all-ones: infinity
                        if (in_e_inc == EXPI_W'(EXP_MAX)) begin
                            f_d = '0;
                        end
                    end
                end
            end
            SHIFT: begin
                f_d = step_f;
                e_d = step_e;
            end
            default: ;
        endcase

        // e==1 without the hidden bit is a subnormal: exponent field reads 0
        out_exp  = ((e_d == EXPI_W'(1)) && !f_d[F_W-1]) ? '0 : e_d[EXP_W-1:0];
        load_out = (state_q != DONE) && (state_d == DONE);
        if (load_out) begin
            out_d.sign = sign_d;
            out_d.exp  = out_exp;
            out_d.frac = f_d[FRAC_W-1:0];
`ifdef FADD_NORM_FLAGS_EN
            flags_d = {out_exp == EXP_MAX,
                       (out_exp == '0) && (f_d != '0),
                       (out_exp == '0) && (f_d == '0)};
`endif
        end

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_q      <= 1'b0;
            e_q         <= '0;
            f_q         <= '0;
            out_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef FADD_NORM_FLAGS_EN
            flags_q     <= '0;
`endif
        end else begin
            sign_q      <= sign_d;
            e_q         <= e_d;
            f_q         <= f_d;
            out_q       <= out_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef FADD_NORM_FLAGS_EN
            flags_q     <= flags_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign busy      = busy_q;
`ifdef FADD_NORM_FLAGS_EN
    assign flags     = flags_q;
`endif

endmodule

// File: doc/fadd_norm_seq.md
Name: fadd_norm_seq

Overview:
Sequential post-adder normalizer for the single-precision FP add path. It consumes the unnormalized sign/exponent/fraction produced by the fadd datapath adder stage: 25-bit magnitude including carry bit, before any left-normalization. It produces a packed IEEE-754 word. Cancellation is normalized by an iterative left-shift FSM (SHIFT_PER_CYCLE bits per cycle), with valid/ready handshakes on both sides. Rounding is truncation, consistent with the adder stage.

Parameters:
SHIFT_PER_CYCLE, 1, maximum left-shift distance per SHIFT cycle; legal values 1, 2, 4, 8.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  upstream operand valid.
in_ready  output  1  block can accept an operand.
in_sign  input  1  result sign from adder stage.
in_exp  input  8  larger operand's biased exponent.
in_frac  input  25  magnitude; bit24 = carry, bit23 = hidden position.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts result.
out  output  32  packed {sign, exp[7:0], frac[22:0]}.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, any state, including mid-shift): state=IDLE; in_ready=1; out_valid=0; out=32'h0; busy=0. Internal regs are cleared and a partial result is discarded.
- States: IDLE, SHIFT, DONE. in_ready=1 only in IDLE. out_valid=1 only in DONE.
- IDLE, in_valid=1: latch sign, exponent (e) and fraction (f), then classify in this priority order:
  - f==0: result +0 (sign forced 0, exponent 0, fraction 0) -> DONE.
  - f[24]==1: f>>=1, e+=1. If new e==8'hFF: result is infinity with the input sign and fraction 0. -> DONE.
  - f[23]==1 or e==0 (input already subnormal): no change -> DONE.
  - Otherwise -> SHIFT.
- SHIFT, each cycle:
  - Compute lz = leading zeros of f[23:0], capped at SHIFT_PER_CYCLE and at e-1.
  - f<<=lz; e-=lz.
  - Exit to DONE when f[23]==1 or e==1 after the update.
- On reaching e==1 with f[23]==0: emitted exponent field is 0 (subnormal); the fraction bits are unchanged.
- Worst case is 23 bits: ceil(23/SHIFT_PER_CYCLE) SHIFT cycles.
- DONE:
  - out is registered on DONE entry: {sign, e, f[22:0]}.
  - out holds stable while out_ready=0.
  - On out_valid & out_ready: -> IDLE, out_valid=0 next cycle. out keeps its last value.
- Latency: accept edge N; out_valid at N+1 if no shift is needed, else at N+1+ceil(k/SHIFT_PER_CYCLE) for a shift of k bits.
- Throughput: one result per (latency+1) cycles minimum. No accept occurs in the same cycle as a DONE handshake.
- Exponent arithmetic uses 9 bits internally; no wrap is possible given the rules above.

Optional Feature:
Macro FADD_NORM_FLAGS_EN.
- Defined: adds output port flags[2:0] = {ovf_inf, subnormal, zero}. flags is registered alongside out, 0 on reset, and valid while out_valid.
- Undefined: the port does not exist. Datapath and timing are identical.

Decomposition:
- Package fadd_pkg:
  - EXP_W=8, FRAC_W=23, EXP_MAX=8'hFF.
  - State enum norm_state_t {IDLE, SHIFT, DONE}.
  - Packed typedef fp32_t {sign, exp, frac}.
- Sub-module fadd_lzc_step: combinational leading-zero count of the top SHIFT_PER_CYCLE bits of a 24-bit fraction. Output saturates at SHIFT_PER_CYCLE.

Test Plan:
- in_sign=0, in_exp=8'h80, in_frac=25'h0400000, S=1 -> 1 SHIFT cycle, out=32'h3F800000, out_valid at accept+2.
- in_exp=8'h7F, in_frac=25'h1000000 -> out=32'h40000000 at accept+1. Then in_exp=8'hFE, in_frac=25'h1800000 -> out=32'h7F800000 (flags=3'b100 with FADD_NORM_FLAGS_EN).
- in_sign=1, in_exp=8'h55, in_frac=0 -> out=32'h00000000, flags=3'b001.
- in_exp=8'h03, in_frac=25'h0000001, S=1 -> 2 SHIFT cycles, out=32'h00000004, flags=3'b010. With S=8, in_exp=8'h90, in_frac=25'h0000001 -> 3 SHIFT cycles, out={0, 8'h79, 0}=32'h3C800000.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out and out_valid stable, in_ready=0. Releasing out_ready -> IDLE next cycle.
- Assert rst mid-SHIFT (asynchronously, between edges) -> immediately out_valid=0, busy=0, out=0, in_ready=1. The next operand is processed normally.
